// File: rtl/mult_issue_ctrl_if.sv
// Request / multiplier / response bundle for mult_issue_ctrl.
// slave is the controller's view; master is the surrounding logic's view.
interface mult_issue_ctrl_if #(
  parameter int TBIT  = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic            req_valid;
  logic            req_ready;
  logic [TBIT-1:0] req_a;
  logic [TBIT-1:0] req_b;
  logic            mult_start;
  logic [TBIT-1:0] mult_a;
  logic [TBIT-1:0] mult_b;
  logic [TBIT-1:0] mult_result;
  logic            mult_done;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [TBIT-1:0] rsp_result;
  logic [CW-1:0]   count;

  modport slave (
    input  req_valid, req_a, req_b, mult_result, mult_done, rsp_ready,
    output req_ready, mult_start, mult_a, mult_b, rsp_valid, rsp_result, count
  );

  modport master (
    output req_valid, req_a, req_b, mult_result, mult_done, rsp_ready,
    input  req_ready, mult_start, mult_a, mult_b, rsp_valid, rsp_result, count
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue/capture controller for the iterative multiplier: request FIFO, one op in flight.
// Define MULT_ISSUE_BYPASS_EN to let a request into an idle, empty controller skip the FIFO.
module mult_issue_ctrl #(
  parameter int TBIT  = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  mult_issue_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DEPTH-1:0][TBIT-1:0] mem_a_q, mem_a_d, mem_b_q, mem_b_d;
  logic [TBIT-1:0]            mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [TBIT-1:0]            rsp_result_q, rsp_result_d;
  logic                       done_q, done_d;

  logic req_ready, empty, push, wr, pop, bypass, done_rise;

  assign req_ready = (count_q != CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.req_valid & req_ready;
  assign done_rise = bus.mult_done & ~done_q;
  assign done_d    = bus.mult_done;

`ifdef MULT_ISSUE_BYPASS_EN
  assign bypass = (state_q == IDLE) && empty && bus.req_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request goes straight to the operand registers, never into the FIFO.
  assign wr = push & ~bypass;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    rsp_result_d = rsp_result_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bypass) begin
          mult_a_d = bus.req_a;
          mult_b_d = bus.req_b;
          state_d  = ISSUE;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        // Only a fresh rising edge counts; a level left over from the last op is ignored.
        if (done_rise) begin
          rsp_result_d = bus.mult_result;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      mult_a_d = mem_a_q[rptr_q];
      mult_b_d = mem_b_q[rptr_q];
      rptr_d   = rptr_q + AW'(1);
    end

    if (wr) begin
      mem_a_d[wptr_q] = bus.req_a;
      mem_b_d[wptr_q] = bus.req_b;
      wptr_d          = wptr_q + AW'(1);
    end

    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      mem_a_q      <= '0;
      mem_b_q      <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      rsp_result_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      rsp_result_q <= rsp_result_d;
      done_q       <= done_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mult_start = (state_q == ISSUE);
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.rsp_valid  = (state_q == HOLD);
  assign bus.rsp_result = rsp_result_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: directed vector table, corner sequences, and randomized
// traffic scored against an in-order queue of a*b products.
module tb_mult_issue_ctrl;
  localparam int TBIT  = 64;
  localparam int DEPTH = 4;
`ifdef MULT_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset;

  mult_issue_ctrl_if #(.TBIT(TBIT), .DEPTH(DEPTH)) mi ();

  mult_issue_ctrl #(.TBIT(TBIT), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mi.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_rsp = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Multiplier stand-in: random latency, done stays high until the next start.
  logic            man_mode, man_done;
  logic [63:0]     man_res, stub_res;
  logic            stub_done;
  logic [2:0]      stub_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stub_cnt  <= '0;
      stub_done <= 1'b0;
      stub_res  <= '0;
    end else if (mi.mult_start) begin
      stub_done <= 1'b0;
      stub_cnt  <= 3'($urandom_range(1, 4));
      stub_res  <= mi.mult_a * mi.mult_b;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 3'd1;
      if (stub_cnt == 3'd1) stub_done <= 1'b1;
    end
  end

  assign mi.mult_done   = man_mode ? man_done : stub_done;
  assign mi.mult_result = man_mode ? man_res  : stub_res;

  // Scoreboard: products in acceptance order; responses must come back in that order.
  logic [63:0] exp_q[$];
  logic        hold_prev, start_due;
  logic [63:0] res_prev;
  logic [63:0] exp_v;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
      start_due = 1'b0;
    end else begin
      if (start_due) chk("b2b_start", mi.mult_start, 1);
      if (hold_prev) begin
        chk("hold_valid", mi.rsp_valid, 1);
        chk("hold_result", mi.rsp_result, res_prev);
      end
      if (mi.mult_start) n_start++;
      if (mi.rsp_valid && mi.rsp_ready) begin
        n_rsp++;
        chk("rsp_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          chk("rsp_result", mi.rsp_result, exp_v);
        end
      end
      if (mi.req_valid && mi.req_ready) exp_q.push_back(mi.req_a * mi.req_b);
      start_due = mi.rsp_valid && mi.rsp_ready && (mi.count != 0);
      hold_prev = mi.rsp_valid && !mi.rsp_ready;
      res_prev  = mi.rsp_result;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b);
    int t;
    logic acc;
    mi.req_a = a; mi.req_b = b; mi.req_valid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge clock);
      acc = mi.req_ready;
      step();
      t++;
    end
    mi.req_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'(acc), 1);
  endtask

  task automatic wait_rsp_valid(input string nm);
    int t;
    t = 0;
    while (!mi.rsp_valid && t < 60) begin step(); t++; end
    if (!mi.rsp_valid) chk(nm, 64'(mi.rsp_valid), 1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'($urandom_range(0, 31));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t, acc, r0;
    logic seen;

    vt[0] = '{64'd2, 64'd3, 64'h6};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFEC, 64'd5, 64'hFFFF_FFFF_FFFF_FF9C};
    vt[3] = '{64'h0, 64'hDEAD_BEEF, 64'h0};
    vt[4] = '{64'h8000_0000_0000_0000, 64'd2, 64'h0};
    vt[5] = '{64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001};
    vt[6] = '{64'h1234_5678, 64'h10, 64'h1_2345_6780};

    reset = 1'b1;
    mi.req_valid = 1'b0; mi.req_a = '0; mi.req_b = '0; mi.rsp_ready = 1'b0;
    man_mode = 1'b0; man_done = 1'b0; man_res = '0;
    repeat (3) step();
    chk("rst_start", mi.mult_start, 0);
    chk("rst_mult_a", mi.mult_a, 0);
    chk("rst_mult_b", mi.mult_b, 0);
    chk("rst_rsp_valid", mi.rsp_valid, 0);
    chk("rst_rsp_result", mi.rsp_result, 0);
    chk("rst_count", mi.count, 0);
    chk("rst_req_ready", mi.req_ready, 1);
    reset = 1'b0;
    step();

    // Single ops from the table, one at a time.
    for (int i = 0; i < 7; i++) begin
      n0 = n_start;
      push(vt[i].a, vt[i].b);
      if (i == 0) begin
        chk("lat_accept_edge", mi.mult_start, 64'(BYP));
        step();
        chk("lat_next_edge", mi.mult_start, 64'(!BYP));
      end
      wait_rsp_valid("vec_rsp_timeout");
      chk("vec_result", mi.rsp_result, vt[i].exp);
      mi.rsp_ready = 1'b1;
      step();
      mi.rsp_ready = 1'b0;
      step();
      chk("vec_one_start", 64'(n_start - n0), 1);
    end

    // Backpressure: fill FIFO behind a held response.
    acc = 0;
    n0 = n_rsp;
    mi.rsp_ready = 1'b0;
    mi.req_valid = 1'b1;
    mi.req_a = 64'd11; mi.req_b = 64'd3;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (mi.req_valid && mi.req_ready) acc++;
      step();
      mi.req_a = 64'(11 + acc); mi.req_b = 64'(3 + acc);
    end
    mi.req_valid = 1'b0;
    chk("full_accepted", 64'(acc), 5);
    chk("full_count", mi.count, 4);
    chk("full_req_ready", mi.req_ready, 0);
    chk("full_rsp_valid", mi.rsp_valid, 1);
    mi.rsp_ready = 1'b1;
    t = 0;
    while (n_rsp - n0 < 5 && t < 100) begin step(); t++; end
    chk("full_drained", 64'(n_rsp - n0), 5);
    chk("full_queue_empty", 64'(exp_q.size()), 0);
    mi.rsp_ready = 1'b0;
    step();

    // Stale done: done held high across ISSUE must not be captured.
    man_mode = 1'b1; man_done = 1'b1; man_res = 64'hBAD;
    step();
    push(64'd7, 64'd7);
    t = 0;
    while (!mi.mult_start && t < 20) begin step(); t++; end
    chk("stale_started", mi.mult_start, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stale_no_capture", mi.rsp_valid, 0);
    end
    man_done = 1'b0;
    step();
    chk("stale_low_no_capture", mi.rsp_valid, 0);
    man_res = 64'd49; man_done = 1'b1;
    step();
    chk("stale_rise_valid", mi.rsp_valid, 1);
    chk("stale_rise_result", mi.rsp_result, 49);
    mi.rsp_ready = 1'b1;
    step();
    mi.rsp_ready = 1'b0;
    step();

    // Reset mid-BUSY with three requests queued.
    man_done = 1'b0;
    step();
    push(64'h21, 64'h2); push(64'h22, 64'h3); push(64'h23, 64'h4); push(64'h24, 64'h5);
    step(); step();
    chk("pre_rst_count", mi.count, 3);
    chk("pre_rst_mult_a", mi.mult_a, 64'h21);
    #3 reset = 1'b1;
    #1;
    chk("arst_start", mi.mult_start, 0);
    chk("arst_mult_a", mi.mult_a, 0);
    chk("arst_mult_b", mi.mult_b, 0);
    chk("arst_rsp_valid", mi.rsp_valid, 0);
    chk("arst_rsp_result", mi.rsp_result, 0);
    chk("arst_count", mi.count, 0);
    chk("arst_req_ready", mi.req_ready, 1);
    step();
    #2 reset = 1'b0;
    n0 = n_start; r0 = n_rsp; seen = 1'b0;
    mi.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) man_done = 1'b1;
      step();
      if (mi.rsp_valid) seen = 1'b1;
    end
    chk("post_rst_no_valid", 64'(seen), 0);
    chk("post_rst_no_start", 64'(n_start - n0), 0);
    chk("post_rst_no_rsp", 64'(n_rsp - r0), 0);
    mi.rsp_ready = 1'b0;
    man_mode = 1'b0;
    step();

    // Randomized traffic with response stalls.
    for (int c = 0; c < 10000; c++) begin
      mi.req_valid = ($urandom_range(0, 9) < 6);
      mi.req_a = pick();
      mi.req_b = pick();
      mi.rsp_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    mi.req_valid = 1'b0;
    mi.rsp_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || mi.rsp_valid) && t < 300) begin step(); t++; end
    chk("rand_drained", 64'(exp_q.size()), 0);
    chk("rand_final_count", mi.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Operand-issue and result-capture controller wrapped around the 64-bit iterative multiplier `mult`. Accepts multiply requests on a valid/ready port, buffers them in a small FIFO, and drives `mult` one operation at a time with a single-cycle `start` pulse. Captures `product` when `done` rises and presents it on a valid/ready response port. Sits directly between the execute-stage issue logic and `mult`.

## Interface
- `TBIT`, 64, operand/result width; matches `mult`.
- `DEPTH`, 4, request FIFO entries; must be a power of two, ≥2.
- `CW`, `$clog2(DEPTH)+1`, width of the `count` port.

- `clock`  in  1  Sole clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  A request is present.
- `req_ready`  out  1  FIFO can accept a request; equals `count != DEPTH`.
- `req_a`  in  TBIT  Multiplicand.
- `req_b`  in  TBIT  Multiplier.
- `mult_start`  out  1  Start pulse to `mult`, one cycle wide.
- `mult_a`  out  TBIT  Multiplicand to `mult`; registered, stable from ISSUE until next ISSUE.
- `mult_b`  out  TBIT  Multiplier to `mult`; same rule as `mult_a`.
- `mult_result`  in  TBIT  `mult` product.
- `mult_done`  in  1  `mult` done (level).
- `rsp_valid`  out  1  `rsp_result` holds a valid product.
- `rsp_ready`  in  1  Consumer accepts the response.
- `rsp_result`  out  TBIT  Captured product (low TBIT bits of a*b).
- `count`  out  CW  Current FIFO occupancy.

## Operation
- Push on `req_valid & req_ready`. Pop when the FSM leaves IDLE or HOLD for ISSUE with the FIFO non-empty. Simultaneous push and pop leave `count` unchanged; this is legal even when full, but `req_ready` is computed from the registered count, so a full FIFO refuses the push that cycle.
- The FIFO is a circular buffer. Read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into `mult_a`/`mult_b` and go to ISSUE.
  - ISSUE: `mult_start=1`; go to BUSY.
  - BUSY: capture `mult_result` into `rsp_result` on a rising edge of `mult_done`. The edge is defined as `mult_done & ~done_q`, where `done_q` is `mult_done` registered. Then go to HOLD.
  - HOLD: `rsp_valid=1`. On `rsp_ready`: go to ISSUE (popping the head) if the FIFO is non-empty, else go to IDLE.
- A `mult_done` that is already high entering BUSY (stale from the previous op) is ignored until it falls and rises again.
- Only one op is in flight at a time. Results return in request order.
- Reset values: `mult_start=0`, `mult_a=0`, `mult_b=0`, `rsp_valid=0`, `rsp_result=0`, `count=0`, pointers 0, `done_q=0`, state IDLE. `req_ready=1` throughout reset.
- Reset mid-operation drops all queued requests, any in-flight op, and any held response. `mult` shares the same `reset`.

## Timing
- Request accepted at edge N into an empty FIFO with FSM in IDLE:
  - edge N+1 enters ISSUE;
  - `mult_start` is high for cycle N+1→N+2;
  - edge N+2 enters BUSY.
- `rsp_valid` rises one edge after the `mult_done` rising edge is sampled.
- Back-to-back: a HOLD handshake at edge M with the FIFO non-empty gives `mult_start` high in cycle M→M+1. There are no idle cycles between ops.
- `rsp_result` and `rsp_valid` hold stable while `rsp_valid & ~rsp_ready`.

## Configuration
- `MULT_ISSUE_BYPASS_EN`:
  - Defined: a request accepted while in IDLE with `count==0` is written straight into `mult_a`/`mult_b`, bypassing the FIFO (`count` stays 0). The state goes to ISSUE at the same edge N, so `mult_start` is high in cycle N→N+1.
  - Undefined: every request passes through the FIFO, giving the latency above. All other behaviour is identical.

## Test plan
- Single op: a=2, b=3 with `rsp_ready=1` -> one `mult_start` pulse; `rsp_result=0x6` with `rsp_valid=1`. Latency from accept to ISSUE is 1 cycle (0 with bypass).
- Signed wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=3 -> `rsp_result=0xFFFF_FFFF_FFFF_FFFD`. Then a=-20, b=5 -> `0xFFFF_FFFF_FFFF_FF9C`, in order.
- Backpressure/full: `rsp_ready=0`, push 6 requests -> exactly 1 in HOLD, 4 queued, `count=4`, `req_ready=0` from the 5th accepted push. Release `rsp_ready` -> 5 results in order with no gap cycles between ISSUEs.
- Stale done: hold `mult_done=1` across ISSUE with a stub `mult` -> no capture until `mult_done` falls then rises.
- Reset mid-BUSY: 3 queued plus 1 in flight, assert `reset` asynchronously -> all outputs go to reset values immediately, `count=0`, and no `rsp_valid` after release.
- Randomized a/b with random `rsp_ready` stalls for 10000 cycles -> every `rsp_result` equals the low 64 bits of a*b, in request order.
